// File: rtl/nodf_mon_pkg.sv
// Shared types for the non-dataflow ap_ctrl handshake monitor.
package nodf_mon_pkg;

    localparam int CNT_W_DEFAULT = 32;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        RUN      = 2'd1,
        WAIT     = 2'd2,
        FINISHED = 2'd3
    } state_t;

endpackage

// File: rtl/nodf_module_intf_sat_counter.sv
// Saturating up-counter with synchronous load and a freeze (hold) input.
module sat_counter #(
    parameter int W = 32
) (
    input  logic         clock,
    input  logic         reset,
    input  logic         inc,
    input  logic         load,
    input  logic [W-1:0] load_val,
    input  logic         hold,
    output logic [W-1:0] count
);

    // hold beats load, load beats inc; increments stop at all-ones
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            count <= '0;
        end else if (!hold) begin
            if (load) begin
                count <= load_val;
            end else if (inc && (count != '1)) begin
                count <= count + 1'b1;
            end
        end
    end

endmodule

// File: rtl/nodf_module_intf.sv
// Status tracker for one non-dataflow HLS module's ap_ctrl handshake:
// transaction state, event counters, latency statistics and protocol errors.
module nodf_module_intf
    import nodf_mon_pkg::*;
#(
    parameter int CNT_W = CNT_W_DEFAULT
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             ap_start,
    input  logic             ap_ready,
    input  logic             ap_done,
    input  logic             ap_continue,
    input  logic             finish,
    output logic [1:0]       state,
    output logic             busy,
    output logic             finished,
    output logic [CNT_W-1:0] start_cnt,
    output logic [CNT_W-1:0] ready_cnt,
    output logic [CNT_W-1:0] done_cnt,
    output logic [CNT_W-1:0] cur_latency,
    output logic [CNT_W-1:0] last_latency,
    output logic [CNT_W-1:0] max_latency,
    output logic [CNT_W-1:0] stall_cycles,
    output logic             err_done_idle
);

    localparam logic [CNT_W-1:0] ONE = CNT_W'(1);

    state_t           cur_state;
    state_t           next_state;
    logic             frozen;
    logic             start_inc;
    logic             ready_inc;
    logic             stall_inc;
    logic             cur_inc;
    logic             cur_load;
    logic [CNT_W-1:0] cur_val;
    logic             complete;
    logic [CNT_W-1:0] lat;
    logic             max_load;
    logic             err_set;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            cur_state <= IDLE;
        end else begin
            cur_state <= next_state;
        end
    end

    always_comb begin
        next_state = cur_state;
        frozen     = finish || (cur_state == FINISHED);
        start_inc  = 1'b0;
        ready_inc  = 1'b0;
        stall_inc  = 1'b0;
        cur_inc    = 1'b0;
        cur_load   = 1'b0;
        cur_val    = '0;
        complete   = 1'b0;
        lat        = '0;
        err_set    = 1'b0;

        if (frozen) begin
            next_state = FINISHED;
        end else begin
            ready_inc = ap_ready;
            unique case (cur_state)
                IDLE: begin
                    if (ap_start) begin
                        start_inc = 1'b1;
                        cur_load  = 1'b1;
                        cur_val   = ONE;
                        // done in the start cycle: the start is not re-counted
                        if (ap_done) begin
                            complete = 1'b1;
                            lat      = ONE;
                            if (ap_continue) begin
                                cur_val = '0;
                            end else begin
                                next_state = WAIT;
                            end
                        end else begin
                            next_state = RUN;
                        end
                    end else if (ap_done) begin
                        err_set = 1'b1;
                    end
                end
                RUN: begin
                    if (ap_done) begin
                        complete = 1'b1;
                        lat      = (cur_latency == '1) ? cur_latency : cur_latency + ONE;
                        if (!ap_continue) begin
                            next_state = WAIT;
                        end else begin
                            cur_load = 1'b1;
                            if (ap_start) begin
                                start_inc = 1'b1;
                                cur_val   = ONE;
                            end else begin
                                next_state = IDLE;
                            end
                        end
                    end else begin
                        cur_inc = 1'b1;
                    end
                end
                WAIT: begin
                    stall_inc = 1'b1;
                    if (ap_continue) begin
                        next_state = IDLE;
                        cur_load   = 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    assign max_load = complete && (lat > max_latency);

    sat_counter #(.W(CNT_W)) u_start_cnt (
        .clock(clock), .reset(reset), .inc(start_inc), .load(1'b0),
        .load_val('0), .hold(frozen), .count(start_cnt)
    );

    sat_counter #(.W(CNT_W)) u_ready_cnt (
        .clock(clock), .reset(reset), .inc(ready_inc), .load(1'b0),
        .load_val('0), .hold(frozen), .count(ready_cnt)
    );

    sat_counter #(.W(CNT_W)) u_done_cnt (
        .clock(clock), .reset(reset), .inc(complete), .load(1'b0),
        .load_val('0), .hold(frozen), .count(done_cnt)
    );

    sat_counter #(.W(CNT_W)) u_cur_latency (
        .clock(clock), .reset(reset), .inc(cur_inc), .load(cur_load),
        .load_val(cur_val), .hold(frozen), .count(cur_latency)
    );

    sat_counter #(.W(CNT_W)) u_last_latency (
        .clock(clock), .reset(reset), .inc(1'b0), .load(complete),
        .load_val(lat), .hold(frozen), .count(last_latency)
    );

    sat_counter #(.W(CNT_W)) u_max_latency (
        .clock(clock), .reset(reset), .inc(1'b0), .load(max_load),
        .load_val(lat), .hold(frozen), .count(max_latency)
    );

    sat_counter #(.W(CNT_W)) u_stall_cycles (
        .clock(clock), .reset(reset), .inc(stall_inc), .load(1'b0),
        .load_val('0), .hold(frozen), .count(stall_cycles)
    );

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            err_done_idle <= 1'b0;
        end else if (err_set) begin
            err_done_idle <= 1'b1;
        end
    end

    assign state    = cur_state;
    assign busy     = (cur_state == RUN) || (cur_state == WAIT);
    assign finished = (cur_state == FINISHED);

endmodule

// File: tb/tb_nodf_module_intf.sv
// Directed bench for nodf_module_intf: transaction-level reference model checked
// every cycle, plus literal expectations for the documented scenarios.
module tb_nodf_module_intf;

    localparam int TW = 4;
    localparam longint MAXV = (longint'(1) << TW) - 1;

    logic          clock = 1'b0;
    logic          reset = 1'b1;
    logic          ap_start = 1'b0;
    logic          ap_ready = 1'b0;
    logic          ap_done = 1'b0;
    logic          ap_continue = 1'b0;
    logic          finish = 1'b0;
    logic [1:0]    state;
    logic          busy;
    logic          finished;
    logic [TW-1:0] start_cnt, ready_cnt, done_cnt, cur_latency;
    logic [TW-1:0] last_latency, max_latency, stall_cycles;
    logic          err_done_idle;

    int tests = 0;
    int fails = 0;

    nodf_module_intf #(.CNT_W(TW)) dut (
        .clock(clock), .reset(reset), .ap_start(ap_start), .ap_ready(ap_ready),
        .ap_done(ap_done), .ap_continue(ap_continue), .finish(finish),
        .state(state), .busy(busy), .finished(finished),
        .start_cnt(start_cnt), .ready_cnt(ready_cnt), .done_cnt(done_cnt),
        .cur_latency(cur_latency), .last_latency(last_latency),
        .max_latency(max_latency), .stall_cycles(stall_cycles),
        .err_done_idle(err_done_idle)
    );

    always #5 clock = ~clock;

    task automatic chk(input string name, input longint act, input longint exp);
        tests++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference model: latency is the cycle-number distance from the accepted start.
    int     m_state;   // 0 idle, 1 run, 2 wait, 3 finished
    longint m_start, m_ready, m_done, m_cur, m_last, m_max, m_stall;
    bit     m_err;
    longint cyc, t0;

    function automatic longint sat(input longint v);
        return (v > MAXV) ? MAXV : v;
    endfunction

    task automatic m_complete(input longint l);
        m_done = sat(m_done + 1);
        m_last = l;
        if (l > m_max) m_max = l;
    endtask

    always @(posedge clock or posedge reset) begin
        if (reset) begin
            m_state = 0; m_start = 0; m_ready = 0; m_done = 0; m_cur = 0;
            m_last = 0; m_max = 0; m_stall = 0; m_err = 0; cyc = 0; t0 = 0;
        end else begin
            if (finish || m_state == 3) begin
                m_state = 3;
            end else begin
                if (ap_ready) m_ready = sat(m_ready + 1);
                case (m_state)
                    0: if (ap_start) begin
                        m_start = sat(m_start + 1);
                        t0 = cyc;
                        m_cur = 1;
                        if (ap_done) begin
                            m_complete(1);
                            if (ap_continue) m_cur = 0;
                            else m_state = 2;
                        end else begin
                            m_state = 1;
                        end
                    end else if (ap_done) begin
                        m_err = 1;
                    end
                    1: if (ap_done) begin
                        m_complete(sat(cyc - t0 + 1));
                        if (!ap_continue) begin
                            m_state = 2;
                        end else if (ap_start) begin
                            m_start = sat(m_start + 1);
                            t0 = cyc;
                            m_cur = 1;
                        end else begin
                            m_state = 0;
                            m_cur = 0;
                        end
                    end else begin
                        m_cur = sat(cyc - t0 + 1);
                    end
                    default: begin
                        m_stall = sat(m_stall + 1);
                        if (ap_continue) begin
                            m_state = 0;
                            m_cur = 0;
                        end
                    end
                endcase
            end
            cyc++;
        end
    end

    always @(negedge clock) begin
        if (!reset) begin
            chk("state", longint'(state), m_state);
            chk("busy", longint'(busy), longint'(m_state == 1 || m_state == 2));
            chk("finished", longint'(finished), longint'(m_state == 3));
            chk("start_cnt", longint'(start_cnt), m_start);
            chk("ready_cnt", longint'(ready_cnt), m_ready);
            chk("done_cnt", longint'(done_cnt), m_done);
            chk("cur_latency", longint'(cur_latency), m_cur);
            chk("last_latency", longint'(last_latency), m_last);
            chk("max_latency", longint'(max_latency), m_max);
            chk("stall_cycles", longint'(stall_cycles), m_stall);
            chk("err_done_idle", longint'(err_done_idle), longint'(m_err));
        end
    end

    task automatic drive(input logic s, input logic r, input logic d, input logic c, input logic f);
        ap_start = s; ap_ready = r; ap_done = d; ap_continue = c; finish = f;
        @(posedge clock);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        ap_start = 0; ap_ready = 0; ap_done = 0; ap_continue = 0; finish = 0;
        @(posedge clock);
        @(posedge clock);
        #1;
        reset = 1'b0;
    endtask

    initial begin
        do_reset();
        chk("rst_state", longint'(state), 0);
        chk("rst_start_cnt", longint'(start_cnt), 0);
        chk("rst_max_latency", longint'(max_latency), 0);
        chk("rst_err", longint'(err_done_idle), 0);

        // 1: start at cycle 0, done at cycle 4
        drive(1, 0, 0, 1, 0);
        chk("t1_cur_after_start", longint'(cur_latency), 1);
        chk("t1_busy", longint'(busy), 1);
        drive(0, 1, 0, 1, 0);
        drive(0, 0, 0, 1, 0);
        drive(0, 1, 0, 1, 0);
        drive(1, 0, 1, 1, 0);   // start high on done goes back-to-back; avoid it here
        // the line above also exercises back-to-back; undo by checking counts explicitly
        chk("t1_done_cnt", longint'(done_cnt), 1);
        chk("t1_last", longint'(last_latency), 5);
        chk("t1_max", longint'(max_latency), 5);
        chk("t1_start_cnt_b2b", longint'(start_cnt), 2);
        chk("t1_state_b2b", longint'(state), 1);
        drive(0, 0, 1, 1, 0);   // second transaction: latency 2
        chk("t1b_last", longint'(last_latency), 2);
        chk("t1b_state", longint'(state), 0);
        chk("t1b_cur", longint'(cur_latency), 0);
        chk("t1_ready_cnt", longint'(ready_cnt), 2);

        // 2: same-cycle start/done/continue
        drive(1, 0, 1, 1, 0);
        chk("t2_last", longint'(last_latency), 1);
        chk("t2_state", longint'(state), 0);
        chk("t2_start_cnt", longint'(start_cnt), 3);
        chk("t2_max", longint'(max_latency), 5);

        // 3: done with continue low, three more stalled cycles, then continue
        drive(1, 0, 0, 0, 0);
        drive(0, 0, 1, 0, 0);
        chk("t3_state_wait", longint'(state), 2);
        chk("t3_last", longint'(last_latency), 2);
        for (int i = 0; i < 3; i++) drive(0, 0, 0, 0, 0);
        chk("t3_state_still_wait", longint'(state), 2);
        drive(0, 0, 0, 1, 0);
        chk("t3_stall", longint'(stall_cycles), 4);
        chk("t3_state_idle", longint'(state), 0);

        // 4: back-to-back 3 then 7 cycles; start held in RUN is not a new start
        drive(1, 0, 0, 1, 0);
        drive(0, 0, 0, 1, 0);
        drive(1, 0, 1, 1, 0);
        chk("t4_first_last", longint'(last_latency), 3);
        drive(0, 0, 0, 1, 0);
        drive(1, 0, 0, 1, 0);
        drive(1, 0, 0, 1, 0);
        drive(0, 0, 0, 1, 0);
        drive(0, 0, 0, 1, 0);
        drive(0, 0, 1, 1, 0);
        chk("t4_start_cnt", longint'(start_cnt), 6);
        chk("t4_last", longint'(last_latency), 7);
        chk("t4_max", longint'(max_latency), 7);

        // saturation: long transaction and many quick ones
        drive(1, 1, 0, 1, 0);
        for (int i = 0; i < 20; i++) drive(0, 1, 0, 1, 0);
        chk("sat_cur", longint'(cur_latency), MAXV);
        chk("sat_ready", longint'(ready_cnt), MAXV);
        drive(0, 0, 1, 1, 0);
        chk("sat_last", longint'(last_latency), MAXV);
        chk("sat_max", longint'(max_latency), MAXV);
        for (int i = 0; i < 12; i++) drive(1, 0, 1, 1, 0);
        chk("sat_start", longint'(start_cnt), MAXV);
        chk("sat_done", longint'(done_cnt), MAXV);
        chk("sat_last_small", longint'(last_latency), 1);

        // 6: done in IDLE raises the sticky error
        chk("err_before", longint'(err_done_idle), 0);
        drive(0, 0, 1, 1, 0);
        drive(0, 0, 0, 1, 0);
        chk("err_sticky", longint'(err_done_idle), 1);

        // 6: asynchronous reset in the middle of RUN
        drive(1, 0, 0, 1, 0);
        drive(0, 0, 0, 1, 0);
        #1 reset = 1'b1;
        #1;
        chk("arst_state", longint'(state), 0);
        chk("arst_busy", longint'(busy), 0);
        chk("arst_start", longint'(start_cnt), 0);
        chk("arst_cur", longint'(cur_latency), 0);
        chk("arst_max", longint'(max_latency), 0);
        chk("arst_err", longint'(err_done_idle), 0);
        @(posedge clock);
        #1 reset = 1'b0;
        drive(0, 0, 0, 1, 0);
        chk("arst_no_resume", longint'(state), 0);

        // 5: idle inputs, then finish with activity in the same and later cycles
        for (int i = 0; i < 4; i++) drive(0, 0, 0, 0, 0);
        chk("t5_start", longint'(start_cnt), 0);
        chk("t5_ready", longint'(ready_cnt), 0);
        chk("t5_err", longint'(err_done_idle), 0);
        drive(1, 1, 0, 1, 1);
        chk("t5_finished", longint'(finished), 1);
        chk("t5_state", longint'(state), 3);
        chk("t5_finish_cycle_start", longint'(start_cnt), 0);
        chk("t5_finish_cycle_ready", longint'(ready_cnt), 0);
        drive(1, 1, 1, 1, 0);
        drive(0, 1, 1, 0, 0);
        drive(1, 0, 1, 1, 0);
        chk("t5_frozen_start", longint'(start_cnt), 0);
        chk("t5_frozen_ready", longint'(ready_cnt), 0);
        chk("t5_frozen_done", longint'(done_cnt), 0);
        chk("t5_frozen_err", longint'(err_done_idle), 0);
        chk("t5_still_finished", longint'(state), 3);

        @(negedge clock);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
